// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtc_pkg
// Description : Shared encodings and field widths for the RTC timekeeper.
// Revision    : 1.0
// ============================================================================
package rtc_pkg;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HR_W    = 5;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  typedef enum logic [0:0] {
    MODE_CLOCK = 1'b0,
    MODE_SETUP = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC = 2'b00,
    POS_MIN = 2'b01,
    POS_HR  = 2'b10
  } pos_e;

  function automatic pos_e next_pos(input pos_e p);
    case (p)
      POS_SEC: next_pos = POS_MIN;
      POS_MIN: next_pos = POS_HR;
      default: next_pos = POS_SEC;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_field_cnt.sv
`default_nettype none
// ============================================================================
// Module      : rtc_field_cnt
// Description : Wrapping time-field counter; wrap flags an increment at MAX.
// Revision    : 1.0
// ============================================================================
module rtc_field_cnt #(
  parameter int WIDTH = 6,
  parameter int MAX   = 59
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] value_next,
  output logic             wrap
);

  logic [WIDTH-1:0] r_value;

  assign wrap  = inc && (r_value == WIDTH'(MAX));
  assign value = r_value;

  always_comb begin
    value_next = r_value;
    if (wrap)
      value_next = '0;
    else if (inc)
      value_next = r_value + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_value <= '0;
    else
      r_value <= value_next;
  end

endmodule
`default_nettype wire

// File: rtl/rtc_timekeeper.sv
`default_nettype none
// ============================================================================
// Module      : rtc_timekeeper
// Description : Clock-enabled hh:mm:ss timekeeper with setup mode and alarm.
// Revision    : 1.0
// ============================================================================
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int HR_MAX    = 23,
  parameter int BLINK_DIV = 12500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_mode_pls,
  input  logic             i_pos_pls,
  input  logic             i_inc_pls,
  input  logic             i_alarm_en,
  input  logic [HR_W-1:0]  i_alarm_hr,
  input  logic [MIN_W-1:0] i_alarm_min,
  input  logic             i_alarm_clr,
  output logic [SEC_W-1:0] o_sec,
  output logic [MIN_W-1:0] o_min,
  output logic [HR_W-1:0]  o_hr,
  output logic             o_mode,
  output logic [1:0]       o_position,
  output logic             o_sec_tick,
  output logic             o_day_tick,
  output logic             o_blink,
  output logic             o_alarm
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [PW-1:0] c_tick_last  = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] c_blink_last = BW'(BLINK_DIV - 1);

  mode_e            r_mode;
  pos_e             r_pos;
  logic [PW-1:0]    r_presc;
  logic [BW-1:0]    r_blink_cnt;
  logic             r_blink;
  logic             r_sec_tick;
  logic             r_day_tick;
  logic             r_alarm;

  logic             w_clock;
  logic             w_tick;
  logic             w_edit_inc;
  logic             w_edit_pos;
  logic             w_sec_en, w_min_en, w_hr_en;
  logic             w_sec_wrap, w_min_wrap, w_hr_wrap;
  logic             w_carry_min, w_carry_hr;
  logic             w_alarm_hit;
  logic [SEC_W-1:0] w_sec_next;
  logic [MIN_W-1:0] w_min_next;
  logic [HR_W-1:0]  w_hr_next;

  assign w_clock    = (r_mode == MODE_CLOCK);
  assign w_tick     = w_clock && (r_presc == c_tick_last);
  // A mode pulse wins over any same-cycle edit request.
  assign w_edit_inc = !w_clock && !i_mode_pls && i_inc_pls;
  assign w_edit_pos = !w_clock && !i_mode_pls && i_pos_pls;

  assign w_carry_min = w_tick && w_sec_wrap;
  assign w_carry_hr  = w_carry_min && w_min_wrap;

  assign w_sec_en = w_tick      || (w_edit_inc && r_pos == POS_SEC);
  assign w_min_en = w_carry_min || (w_edit_inc && r_pos == POS_MIN);
  assign w_hr_en  = w_carry_hr  || (w_edit_inc && r_pos == POS_HR);

  rtc_field_cnt #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst_n(rst_n), .inc(w_sec_en),
    .value(o_sec), .value_next(w_sec_next), .wrap(w_sec_wrap)
  );

  rtc_field_cnt #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk(clk), .rst_n(rst_n), .inc(w_min_en),
    .value(o_min), .value_next(w_min_next), .wrap(w_min_wrap)
  );

  rtc_field_cnt #(.WIDTH(HR_W), .MAX(HR_MAX)) u_hr (
    .clk(clk), .rst_n(rst_n), .inc(w_hr_en),
    .value(o_hr), .value_next(w_hr_next), .wrap(w_hr_wrap)
  );

  // Next values are always in range, so out-of-range alarm settings never hit.
  assign w_alarm_hit = w_tick && i_alarm_en && (w_sec_next == '0) &&
                       (w_min_next == i_alarm_min) && (w_hr_next == i_alarm_hr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_presc <= '0;
    else if (!w_clock || i_mode_pls || w_tick)
      r_presc <= '0;
    else
      r_presc <= r_presc + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_CLOCK;
      r_pos  <= POS_SEC;
    end else if (i_mode_pls) begin
      r_mode <= w_clock ? MODE_SETUP : MODE_CLOCK;
      if (w_clock)
        r_pos <= POS_SEC;
    end else if (w_edit_pos) begin
      r_pos <= next_pos(r_pos);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (w_clock || i_mode_pls) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (r_blink_cnt == c_blink_last) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec_tick <= 1'b0;
      r_day_tick <= 1'b0;
      r_alarm    <= 1'b0;
    end else begin
      r_sec_tick <= w_tick;
      r_day_tick <= w_carry_hr && w_hr_wrap;
      if (!i_alarm_en || i_alarm_clr)
        r_alarm <= 1'b0;
      else if (w_alarm_hit)
        r_alarm <= 1'b1;
    end
  end

  assign o_mode     = r_mode;
  assign o_position = r_pos;
  assign o_sec_tick = r_sec_tick;
  assign o_day_tick = r_day_tick;
  assign o_blink    = r_blink;
  assign o_alarm    = r_alarm;

endmodule
`default_nettype wire

// File: doc/rtc_timekeeper.md
Name: rtc_timekeeper

Overview:
Single-clock, parametrised hour:minute:second timekeeper that replaces the derived-clock counter/controller pair with clock-enable logic. It owns the 1 Hz prescaler, the sec/min/hr carry chain with correct 24 h or 12 h hour wrap, setup mode with per-field increment, a field-blink strobe and a minute-resolution alarm. It sits between the debounced push-button pulses and the digit-split/7-segment display path.

Parameters:
TICK_DIV, 50000000, clk cycles per second tick (>=2)
HR_MAX, 23, last hour value before wrap (legal: 23 or 11)
BLINK_DIV, 12500000, clk cycles per o_blink half-period in setup mode (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
i_mode_pls  in  1  one-cycle pulse, toggle CLOCK/SETUP mode
i_pos_pls  in  1  one-cycle pulse, advance setup field
i_inc_pls  in  1  one-cycle pulse, increment selected field
i_alarm_en  in  1  alarm enable level
i_alarm_hr  in  5  alarm hour
i_alarm_min  in  6  alarm minute
i_alarm_clr  in  1  one-cycle pulse, clear active alarm
o_sec  out  6  seconds 0..59
o_min  out  6  minutes 0..59
o_hr  out  5  hours 0..HR_MAX
o_mode  out  1  0 = CLOCK, 1 = SETUP
o_position  out  2  00 = SEC, 01 = MIN, 10 = HR (11 never produced)
o_sec_tick  out  1  one-cycle pulse, seconds advanced by prescaler
o_day_tick  out  1  one-cycle pulse, hr wrapped HR_MAX->0 by carry
o_blink  out  1  display gate for the selected field
o_alarm  out  1  alarm active level

Behaviour:
- Reset (async, immediate, also mid-operation): all counters 0, o_mode CLOCK, o_position SEC, o_sec_tick/o_day_tick/o_alarm 0, o_blink 1, prescaler and blink counter 0.
- All inputs synchronous to clk; all outputs registered.
- Prescaler: counts 0..TICK_DIV-1 in CLOCK mode only; at TICK_DIV-1 it wraps to 0 and seconds advance on the same edge. o_sec_tick is high in the cycle the new o_sec appears. First tick after reset or after leaving SETUP occurs exactly TICK_DIV cycles later.
- Carry chain (CLOCK mode): sec 59->0 increments min; min 59->0 increments hr; hr HR_MAX->0 asserts o_day_tick, coincident with that o_sec_tick. All fields update on one edge; no intermediate values are visible.
- Mode: i_mode_pls toggles o_mode. Entering SETUP sets o_position SEC, holds the prescaler at 0 and freezes time. Leaving SETUP restarts the prescaler from 0.
- SETUP: i_pos_pls cycles SEC->MIN->HR->SEC. i_inc_pls increments only the selected field, wraps at its max (59/59/HR_MAX), never carries, and never asserts o_sec_tick/o_day_tick. In CLOCK mode, i_pos_pls and i_inc_pls are ignored.
- Simultaneous events:
  - mode + inc or pos: mode toggles; inc/pos ignored.
  - pos + inc: inc applies to the old position, then position advances.
- o_blink: in CLOCK mode held at 1. In SETUP mode toggles every BLINK_DIV cycles, starting at 1 on entry.
- Alarm:
  - Set condition: CLOCK mode, i_alarm_en=1, and the carry-chain update produces o_sec=0, o_min=i_alarm_min, o_hr=i_alarm_hr. On that edge o_alarm goes to 1.
  - o_alarm holds until i_alarm_clr or i_alarm_en=0; clear has priority over set in the same cycle.
  - Setup edits never set the alarm.
  - Out-of-range alarm values never match.

Decomposition:
- Shared package rtc_pkg: MODE_CLOCK/MODE_SETUP, POS_SEC/POS_MIN/POS_HR encodings, SEC_MAX=59, MIN_MAX=59, field width constants.
- One sub-module rtc_field_cnt, parametrised by width and max: increment enable, wrap flag output. Instantiated three times (sec/min/hr).
- Prescaler, mode/position FSM, blink and alarm logic stay in the top module.

Test Plan:
1. Reset with TICK_DIV=4: hold rst_n low -> all outputs 0 except o_blink=1. Release, run 8 cycles -> o_sec=2, o_sec_tick pulsed on cycles 4 and 8.
2. Set 23:59:58 via SETUP, return to CLOCK, 2 ticks -> 23:59:59 then 00:00:00; o_day_tick high exactly one cycle, same cycle as o_sec_tick.
3. SETUP, pos to MIN, 61 inc pulses from min=0 -> o_min=1, o_hr and o_sec unchanged. Repeat with HR_MAX=11 on HR, 12 pulses -> o_hr=0.
4. Enter SETUP mid-second (prescaler=2), wait 20 cycles -> o_sec frozen, no o_sec_tick. Exit -> next o_sec_tick exactly 4 cycles later.
5. Alarm 07:30, i_alarm_en=1, time 07:29:59, one tick -> o_alarm=1 on the 07:30:00 edge. i_alarm_clr together with a new match -> o_alarm=0.
6. In SETUP at SEC: i_pos_pls+i_inc_pls same cycle -> o_sec+1, o_position=MIN. i_mode_pls+i_inc_pls -> mode CLOCK, no field change.
